// File: rtl/walk_pkg.sv
// Shared definitions for the pedestrian walk-button front end.
package walk_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } walk_state_e;

  localparam int DEFAULT_DEBOUNCE = 8;
  localparam int PRESS_CNT_W      = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pedestrian/sensor inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             Reset_Sync,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/walk_button_sync.sv
// Walk push-button conditioner: synchronise, debounce, one WR_Sync pulse per press.
// Define WALK_PRESS_COUNT_EN to add the saturating Press_Count output.
module walk_button_sync
  import walk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int CNT_W           = 4
) (
  input  logic                   clk,
  input  logic                   Reset_Sync,
  input  logic                   Walk_Request,
  output logic                   WR_Sync,
  output logic                   Btn_Stable
`ifdef WALK_PRESS_COUNT_EN
  ,
  output logic [PRESS_CNT_W-1:0] Press_Count
`endif
);

  logic             s2;
  walk_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_sync_q, wr_sync_d;
  logic             btn_stable_q, btn_stable_d;
  logic             last_sample;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk        (clk),
    .Reset_Sync (Reset_Sync),
    .d          (Walk_Request),
    .q          (s2)
  );

  // The current s2 sample completes the debounce window.
  assign last_sample = ((int'(cnt_q) + 1) == DEBOUNCE_CYCLES);

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_sync_q    <= 1'b0;
      btn_stable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_sync_q    <= wr_sync_d;
      btn_stable_q <= btn_stable_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_sync_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = HELD;
            cnt_d     = '0;
            wr_sync_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last_sample) begin
          state_d   = HELD;
          cnt_d     = '0;
          wr_sync_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        // A high sample here is release bounce; return to HELD without a new pulse.
        if (s2) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (last_sample) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    btn_stable_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  assign WR_Sync    = wr_sync_q;
  assign Btn_Stable = btn_stable_q;

`ifdef WALK_PRESS_COUNT_EN
  logic [PRESS_CNT_W-1:0] press_count_q;

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      press_count_q <= '0;
    end else if (wr_sync_d && (press_count_q != '1)) begin
      press_count_q <= press_count_q + PRESS_CNT_W'(1);
    end
  end

  assign Press_Count = press_count_q;
`endif

endmodule

// File: tb/tb_walk_button_sync.sv
// Directed bench for walk_button_sync with a history-window reference model.
module tb_walk_button_sync;
  import walk_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic Reset_Sync = 1'b1;
  logic Walk_Request = 1'b0;
  logic WR_Sync;
  logic Btn_Stable;
`ifdef WALK_PRESS_COUNT_EN
  logic [7:0] Press_Count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int edgeNum     = 0;
  int pulseCount  = 0;
  int lastPulseEdge = -1;
  int fallEdge    = -1;
  int start       = 0;
  logic prevBtn   = 1'b0;

  logic mS1 = 1'b0, mS2 = 1'b0, mStable = 1'b0, mPulse = 1'b0;
  int   mCount = 0;
  logic hist[$];
  logic allOpposite;

  always #5 clk = ~clk;

  walk_button_sync dut (
    .clk          (clk),
    .Reset_Sync   (Reset_Sync),
    .Walk_Request (Walk_Request),
    .WR_Sync      (WR_Sync),
    .Btn_Stable   (Btn_Stable)
`ifdef WALK_PRESS_COUNT_EN
    ,
    .Press_Count  (Press_Count)
`endif
  );

  // Reference: the debounced level flips once the last D synchronised samples all disagree with it.
  always @(posedge clk) begin
    edgeNum++;
    mPulse = 1'b0;
    if (Reset_Sync) begin
      mS1 = 1'b0;
      mS2 = 1'b0;
      mStable = 1'b0;
      mCount = 0;
      hist.delete();
    end else begin
      hist.push_back(mS2);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        allOpposite = 1'b1;
        foreach (hist[i]) if (hist[i] == mStable) allOpposite = 1'b0;
        if (allOpposite) begin
          mStable = ~mStable;
          if (mStable) begin
            mPulse = 1'b1;
            if (mCount < 255) mCount++;
          end
        end
      end
      mS2 = mS1;
      mS1 = Walk_Request;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at edge %0d: actual=%0d required=%0d", name, edgeNum, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input int cycles);
    Reset_Sync   = rst;
    Walk_Request = wr;
    repeat (cycles) @(negedge clk);
  endtask

  always @(negedge clk) begin
    checkOutput("wr_sync", {7'd0, WR_Sync}, {7'd0, mPulse});
    checkOutput("btn_stable", {7'd0, Btn_Stable}, {7'd0, mStable});
`ifdef WALK_PRESS_COUNT_EN
    checkOutput("press_count", Press_Count, 8'(mCount));
`endif
    if (WR_Sync === 1'b1) begin
      pulseCount++;
      lastPulseEdge = edgeNum;
    end
    if (prevBtn === 1'b1 && Btn_Stable === 1'b0) fallEdge = edgeNum;
    prevBtn = Btn_Stable;
  end

  initial begin
    // 1: reset held with the button pressed, then a press confirmed at edge 13 (3 reset edges + 10).
    applyStimulus(1'b1, 1'b1, 3);
    #1;
    checkOutput("reset_wr_sync", {7'd0, WR_Sync}, 8'd0);
    checkOutput("reset_btn_stable", {7'd0, Btn_Stable}, 8'd0);
    applyStimulus(1'b0, 1'b1, 30);
    #1;
    checkOutput("t1_pulse_edge", 8'(lastPulseEdge), 8'd13);
    checkOutput("t1_pulse_count", 8'(pulseCount), 8'd1);
    applyStimulus(1'b0, 1'b0, 20);
    #1;
    checkOutput("t1_released", {7'd0, Btn_Stable}, 8'd0);

    // 2: clean press, one pulse ten edges after the first high sample.
    pulseCount = 0;
    start = edgeNum;
    applyStimulus(1'b0, 1'b1, 30);
    #1;
    checkOutput("t2_pulse_offset", 8'(lastPulseEdge - start), 8'd10);
    checkOutput("t2_pulse_count", 8'(pulseCount), 8'd1);
    checkOutput("t2_btn_held", {7'd0, Btn_Stable}, 8'd1);
    applyStimulus(1'b0, 1'b0, 20);

    // 3: press bounce never reaches eight consecutive samples.
    pulseCount = 0;
    applyStimulus(1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 20);
    #1;
    checkOutput("t3_pulse_count", 8'(pulseCount), 8'd0);
    checkOutput("t3_btn", {7'd0, Btn_Stable}, 8'd0);

    // 4: release bounce keeps the button held; final release confirmed 10 edges after the low is driven.
    pulseCount = 0;
    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b1, 2);
    #1;
    checkOutput("t4_btn_through_bounce", {7'd0, Btn_Stable}, 8'd1);
    start = edgeNum;
    applyStimulus(1'b0, 1'b0, 20);
    #1;
    checkOutput("t4_fall_offset", 8'(fallEdge - start), 8'd10);
    checkOutput("t4_pulse_count", 8'(pulseCount), 8'd1);

    // 5: reset on edge 9 of a press drops the pulse; new pulse 10 edges after reset releases.
    pulseCount = 0;
    start = edgeNum;
    applyStimulus(1'b0, 1'b1, 8);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 30);
    #1;
    checkOutput("t5_pulse_offset", 8'(lastPulseEdge - start), 8'd19);
    checkOutput("t5_pulse_count", 8'(pulseCount), 8'd1);
    applyStimulus(1'b0, 1'b0, 20);

`ifdef WALK_PRESS_COUNT_EN
    // 6: press counter counts confirmed presses and saturates.
    applyStimulus(1'b1, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 12);
      applyStimulus(1'b0, 1'b0, 12);
    end
    #1;
    checkOutput("t6_count_3", Press_Count, 8'd3);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b1, 12);
      applyStimulus(1'b0, 1'b0, 12);
    end
    #1;
    checkOutput("t6_count_sat", Press_Count, 8'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
